// File: rtl/pla_vector_scanner.sv
// pla_vector_scanner: drives every input vector to a reference and an optimized PLA netlist,
// flags the first output disagreement and compacts the optimized output into a MISR signature.
module pla_vector_scanner #(
    parameter int          N_IN   = 19,
    parameter int          SETTLE = 0,
    parameter int          SIG_W  = 32,
    parameter logic [31:0] POLY   = 32'h04C11DB7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             stop_on_mismatch,
    output logic [N_IN-1:0]  x,
    input  logic             y_ref,
    input  logic             y_dut,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [N_IN-1:0]  fail_vec,
    output logic [SIG_W-1:0] signature,
    output logic [N_IN:0]    vec_count
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state;
    logic [7:0]       r_settle;
    logic             r_stop;
    logic [N_IN-1:0]  r_x;
    logic [N_IN-1:0]  r_fail;
    logic             r_busy;
    logic             r_done;
    logic             r_mis;
    logic [SIG_W-1:0] r_sig;
    logic [N_IN:0]    r_cnt;
    logic             w_sample;
    logic             w_diff;
    logic             w_finish;
    logic [SIG_W-1:0] w_sig_next;
    assign w_sample   = r_settle == SETTLE[7:0];
    assign w_diff     = y_ref ^ y_dut;
    // a scan ends on the last vector, on a stopping mismatch, or on abort (sample still taken first)
    assign w_finish   = abort || (w_sample && ((&r_x) || (w_diff && r_stop)));
    assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? POLY[SIG_W-1:0] : '0) ^ SIG_W'(y_dut);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_settle <= '0;
            r_stop   <= 1'b0;
            r_x      <= '0;
            r_fail   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_mis    <= 1'b0;
            r_sig    <= '0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_x      <= '0;
                    r_sig    <= '0;
                    r_cnt    <= '0;
                    r_mis    <= 1'b0;
                    r_fail   <= '0;
                    r_settle <= '0;
                    r_stop   <= stop_on_mismatch;
                    r_busy   <= 1'b1;
                    r_state  <= RUN;
                end
                RUN: begin
                    if (w_sample) begin
                        r_sig <= w_sig_next;
                        r_cnt <= r_cnt + (N_IN+1)'(1);
                        if (w_diff && !r_mis) begin
                            r_mis  <= 1'b1;
                            r_fail <= r_x;
                        end
                    end
                    if (w_finish) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_sample) begin
                        r_x      <= r_x + N_IN'(1);
                        r_settle <= '0;
                    end else begin
                        r_settle <= r_settle + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign x         = r_x;
    assign busy      = r_busy;
    assign done      = r_done;
    assign mismatch  = r_mis;
    assign fail_vec  = r_fail;
    assign signature = r_sig;
    assign vec_count = r_cnt;
endmodule

// File: tb/tb_pla_vector_scanner.sv
// tb_pla_vector_scanner: two scanners (SETTLE 0 and 2) checked every cycle against a closed-form
// scan model, plus directed literal expectations for the main scenarios.
module tb_pla_vector_scanner;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       rst;
    logic       start [2];
    logic       abort [2];
    logic       stop  [2];
    logic       inv_a [2];
    logic       inv_c [2];
    logic [3:0] x     [2];
    logic       y_ref [2];
    logic       y_dut [2];
    logic       busy  [2];
    logic       done  [2];
    logic       mism  [2];
    logic [3:0] fvec  [2];
    logic [7:0] sig   [2];
    logic [4:0] vcnt  [2];
    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    function automatic logic yd(logic [3:0] v, logic ia, logic ic);
        return v[0] ^ (ia && v == 4'hA) ^ (ic && v == 4'hC);
    endfunction

    assign y_ref[0] = x[0][0];
    assign y_ref[1] = x[1][0];
    assign y_dut[0] = yd(x[0], inv_a[0], inv_c[0]);
    assign y_dut[1] = yd(x[1], inv_a[1], inv_c[1]);

    pla_vector_scanner #(.N_IN(4), .SETTLE(0), .SIG_W(8), .POLY(32'h07)) u_s0 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .stop_on_mismatch(stop[0]),
        .x(x[0]), .y_ref(y_ref[0]), .y_dut(y_dut[0]), .busy(busy[0]), .done(done[0]),
        .mismatch(mism[0]), .fail_vec(fvec[0]), .signature(sig[0]), .vec_count(vcnt[0]));
    pla_vector_scanner #(.N_IN(4), .SETTLE(2), .SIG_W(8), .POLY(32'h07)) u_s2 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .stop_on_mismatch(stop[1]),
        .x(x[1]), .y_ref(y_ref[1]), .y_dut(y_dut[1]), .busy(busy[1]), .done(done[1]),
        .mismatch(mism[1]), .fail_vec(fvec[1]), .signature(sig[1]), .vec_count(vcnt[1]));

    task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s dut%0d got=%0h expected=%0h t=%0t", nm, d, act, exp, $time);
        end
    endtask

    // Model: a scan is fully described by its start, the number of samples E it will take and
    // the edge (relative to start) where it ends; every output follows from those by arithmetic.
    int   phase [2] = '{0, 0};
    int   cnt   [2] = '{0, 0};
    int   e_rel [2] = '{0, 0};
    int   e_smp [2] = '{0, 0};
    logic m_ia  [2];
    logic m_ic  [2];

    function automatic int sp(int d);
        return d == 0 ? 1 : 3;
    endfunction

    function automatic int nat_samples(logic stp, logic ia, logic ic);
        for (int v = 0; v < 16; v++)
            if (stp && yd(4'(v), ia, ic) != v[0]) return v + 1;
        return 16;
    endfunction

    task automatic stats(int n, logic ia, logic ic, output logic [7:0] s, output logic m, output logic [3:0] f);
        s = 8'h00;
        m = 1'b0;
        f = 4'h0;
        for (int v = 0; v < n; v++) begin
            logic y;
            y = yd(4'(v), ia, ic);
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h07 : 8'h00) ^ {7'd0, y};
            if (y != v[0] && !m) begin
                m = 1'b1;
                f = 4'(v);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) phase[d] = 0;
            else if (start[d] && (phase[d] == 0 || cnt[d] > e_rel[d])) begin
                phase[d] = 1;
                cnt[d]   = 0;
                m_ia[d]  = inv_a[d];
                m_ic[d]  = inv_c[d];
                e_smp[d] = nat_samples(stop[d], inv_a[d], inv_c[d]);
                e_rel[d] = e_smp[d] * sp(d);
            end else if (phase[d] == 1) begin
                if (abort[d] && cnt[d] < e_rel[d]) begin
                    e_rel[d] = cnt[d] + 1;
                    if ((cnt[d] + 1) / sp(d) < e_smp[d]) e_smp[d] = (cnt[d] + 1) / sp(d);
                end
                cnt[d]++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) for (int d = 0; d < 2; d++) begin
            int n;
            logic [3:0] ex;
            logic eb, ed, em;
            logic [7:0] es;
            logic [3:0] ef;
            n = 0; ex = 4'h0; eb = 1'b0; ed = 1'b0;
            if (phase[d] == 1) begin
                eb = cnt[d] < e_rel[d];
                ed = cnt[d] == e_rel[d];
                n  = eb ? cnt[d] / sp(d) : e_smp[d];
                ex = eb ? 4'(n) : (e_rel[d] % sp(d) == 0 ? 4'(e_smp[d] - 1) : 4'(e_smp[d]));
            end
            stats(n, m_ia[d], m_ic[d], es, em, ef);
            chk("cyc_x", d, x[d], ex);
            chk("cyc_busy", d, busy[d], eb);
            chk("cyc_done", d, done[d], ed);
            chk("cyc_vcnt", d, vcnt[d], n);
            chk("cyc_sig", d, sig[d], es);
            chk("cyc_mis", d, mism[d], em);
            chk("cyc_fvec", d, fvec[d], ef);
        end
    end

    task automatic go(int d, logic stp);
        @(negedge clk);
        stop[d]  = stp;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    task automatic wait_done(int d, output int edges);
        edges = 0;
        while (!done[d] && edges < 300) begin
            @(negedge clk);
            edges++;
        end
        if (!done[d]) chk("done_timeout", d, 0, 1);
    endtask

    initial begin
        int e;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; abort[d] = 1'b0; stop[d] = 1'b0; inv_a[d] = 1'b0; inv_c[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_x", 0, x[0], 0);
        chk("rst_sig", 0, sig[0], 0);
        chk("rst_vcnt", 1, vcnt[1], 0);
        // clean full scan, SETTLE 0
        go(0, 1'b0);
        wait_done(0, e);
        chk("t1_edges", 0, e, 16);
        chk("t1_sig", 0, sig[0], 8'hF9);
        chk("t1_vcnt", 0, vcnt[0], 16);
        chk("t1_mis", 0, mism[0], 0);
        chk("t1_x", 0, x[0], 4'hF);
        @(negedge clk);
        chk("t1_pulse", 0, done[0], 0);
        // clean full scan, SETTLE 2
        go(1, 1'b0);
        wait_done(1, e);
        chk("t2_edges", 1, e, 48);
        chk("t2_sig", 1, sig[1], 8'hF9);
        chk("t2_vcnt", 1, vcnt[1], 16);
        // stop on first mismatch at A
        inv_a[0] = 1'b1;
        go(0, 1'b1);
        wait_done(0, e);
        chk("t3_edges", 0, e, 11);
        chk("t3_fvec", 0, fvec[0], 4'hA);
        chk("t3_vcnt", 0, vcnt[0], 11);
        chk("t3_mis", 0, mism[0], 1);
        chk("t3_x", 0, x[0], 4'hA);
        // two mismatches, no stop
        inv_c[0] = 1'b1;
        go(0, 1'b0);
        wait_done(0, e);
        chk("t4_edges", 0, e, 16);
        chk("t4_fvec", 0, fvec[0], 4'hA);
        chk("t4_mis", 0, mism[0], 1);
        chk("t4_vcnt", 0, vcnt[0], 16);
        // abort together with the 5th sample; start during RUN ignored
        inv_a[0] = 1'b0;
        inv_c[0] = 1'b0;
        go(0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("t5_done", 0, done[0], 1);
        chk("t5_vcnt", 0, vcnt[0], 5);
        chk("t5_x", 0, x[0], 4);
        @(negedge clk);
        chk("t5_pulse", 0, done[0], 0);
        chk("t5_busy", 0, busy[0], 0);
        repeat (3) @(negedge clk);
        chk("t5_hold", 0, vcnt[0], 5);
        // abort between samples with SETTLE 2
        go(1, 1'b0);
        repeat (3) @(negedge clk);
        abort[1] = 1'b1;
        @(negedge clk);
        abort[1] = 1'b0;
        chk("t5b_done", 1, done[1], 1);
        chk("t5b_vcnt", 1, vcnt[1], 1);
        chk("t5b_x", 1, x[1], 1);
        // reset mid-scan at x=7
        go(0, 1'b0);
        e = 0;
        while (x[0] != 4'h7 && e < 50) begin
            @(negedge clk);
            e++;
        end
        chk("t6_reach", 0, x[0], 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_x", 0, x[0], 0);
        chk("t6_vcnt", 0, vcnt[0], 0);
        chk("t6_sig", 0, sig[0], 0);
        chk("t6_done", 0, done[0], 0);
        chk("t6_busy", 0, busy[0], 0);
        repeat (3) @(negedge clk);
        chk("t6_nodone", 0, done[0], 0);
        go(0, 1'b0);
        wait_done(0, e);
        chk("t6_edges", 0, e, 16);
        chk("t6_vcnt2", 0, vcnt[0], 16);
        chk("t6_sig2", 0, sig[0], 8'hF9);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
